// File: rtl/echo_pkg.sv
// Shared definitions for the echo delay-line controller: default sizes, FSM states
// and the saturating clamp used by the multiply-accumulate datapath.
package echo_pkg;

    localparam int unsigned T_DEF  = 20000;
    localparam int unsigned B_DEF  = 15;
    localparam int unsigned DW_DEF = 24;

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StRd,
        StCalc,
        StWr
    } state_e;

    // Clamp v to the signed range of a w-bit word; caller truncates to w bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/echo_mac.sv
// Computes sat(x + floor(wet * gain / 256)) with an unsigned 8-bit gain.
module echo_mac
    import echo_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic signed [DW-1:0] x_i,
    input  logic signed [DW-1:0] wet_i,
    input  logic [7:0]           gain_i,
    output logic signed [DW-1:0] y_o
);

    logic signed [DW+8:0] wet_ext;
    logic signed [DW+8:0] gain_ext;
    logic signed [DW+8:0] prod;
    logic signed [DW+8:0] scaled;
    logic signed [DW+9:0] sum;

    always_comb begin
        wet_ext  = {{9{wet_i[DW-1]}}, wet_i};
        gain_ext = {{(DW + 1){1'b0}}, gain_i};
        prod     = wet_ext * gain_ext;
        // Arithmetic shift gives floor division for negative products.
        scaled   = prod >>> 8;
        sum      = {{10{x_i[DW-1]}}, x_i} + {scaled[DW+8], scaled};
        y_o      = DW'(saturate({{(54 - DW){sum[DW+9]}}, sum}, DW));
    end

endmodule

// File: rtl/echo_ctrl.sv
// Echo controller: sequences one delay-line read, feedback/mix arithmetic and one
// write per accepted sample, and sweeps the line to zero after reset or on request.
module echo_ctrl
    import echo_pkg::*;
#(
    parameter int unsigned T  = T_DEF,
    parameter int unsigned B  = B_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_valid,
    input  logic signed [DW-1:0] sample_in,
    input  logic [B-1:0]         delay_len,
    input  logic [7:0]           fb_gain,
    input  logic [7:0]           mix_gain,
    input  logic                 clear_req,
    output logic                 bram_we,
    output logic [B-1:0]         bram_addr1,
    output logic [B-1:0]         bram_addr2,
    output logic [31:0]          bram_di,
    input  logic [31:0]          bram_do2,
    output logic signed [DW-1:0] sample_out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic [B:0]   TW  = (B + 1)'(T);
    localparam logic [B-1:0] TM1 = B'(T - 1);

    state_e               state_q, state_d;
    logic [B:0]           clr_cnt_q, clr_cnt_d;
    logic [B-1:0]         wr_ptr_q, wr_ptr_d;
    logic signed [DW-1:0] x_q, x_d;
    logic [7:0]           fbg_q, fbg_d;
    logic [7:0]           mixg_q, mixg_d;
    logic                 we_q, we_d;
    logic [B-1:0]         addr1_q, addr1_d;
    logic [B-1:0]         addr2_q, addr2_d;
    logic [31:0]          di_q, di_d;
    logic signed [DW-1:0] out_q, out_d;
    logic                 ov_q, ov_d;
    logic                 overrun_q, overrun_d;

    logic [B-1:0]         d_eff;
    logic [B-1:0]         rd_addr;
    logic signed [DW-1:0] wet;
    logic signed [DW-1:0] fb_val;
    logic signed [DW-1:0] mix_val;

    assign wet = $signed(bram_do2[DW-1:0]);

    if (DW < 32) begin : g_unused_do2
        logic unused_do2;
        assign unused_do2 = ^bram_do2[31:DW];
    end

    echo_mac #(.DW(DW)) u_fb_mac (
        .x_i    (x_q),
        .wet_i  (wet),
        .gain_i (fbg_q),
        .y_o    (fb_val)
    );

    echo_mac #(.DW(DW)) u_mix_mac (
        .x_i    (x_q),
        .wet_i  (wet),
        .gain_i (mixg_q),
        .y_o    (mix_val)
    );

    always_comb begin
        if (delay_len == '0) begin
            d_eff = B'(1);
        end else if ({1'b0, delay_len} >= TW) begin
            d_eff = TM1;
        end else begin
            d_eff = delay_len;
        end
        if (wr_ptr_q >= d_eff) begin
            rd_addr = wr_ptr_q - d_eff;
        end else begin
            rd_addr = B'(({1'b0, wr_ptr_q} + TW) - {1'b0, d_eff});
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        x_d       = x_q;
        fbg_d     = fbg_q;
        mixg_d    = mixg_q;
        we_d      = 1'b0;
        addr1_d   = addr1_q;
        addr2_d   = addr2_q;
        di_d      = di_q;
        out_d     = out_q;
        ov_d      = 1'b0;
        // Dropped strobe: anything but a plain accept from IDLE.
        overrun_d = sample_valid && ((state_q != StIdle) || clear_req);

        unique case (state_q)
            StClear: begin
                if (clr_cnt_q == TW) begin
                    state_d  = StIdle;
                    wr_ptr_d = '0;
                end else begin
                    we_d      = 1'b1;
                    addr1_d   = clr_cnt_q[B-1:0];
                    di_d      = '0;
                    clr_cnt_d = clr_cnt_q + (B + 1)'(1);
                end
            end
            StIdle: begin
                if (clear_req) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                end else if (sample_valid) begin
                    state_d = StRd;
                    x_d     = sample_in;
                    fbg_d   = fb_gain;
                    mixg_d  = mix_gain;
                    addr2_d = rd_addr;
                end
            end
            StRd: begin
                state_d = StCalc;
            end
            StCalc: begin
                state_d = StWr;
                we_d    = 1'b1;
                addr1_d = wr_ptr_q;
                di_d    = 32'(fb_val);
                out_d   = mix_val;
                ov_d    = 1'b1;
            end
            StWr: begin
                state_d  = StIdle;
                wr_ptr_d = (wr_ptr_q == TM1) ? '0 : wr_ptr_q + B'(1);
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            wr_ptr_q  <= '0;
            x_q       <= '0;
            fbg_q     <= '0;
            mixg_q    <= '0;
            we_q      <= 1'b0;
            addr1_q   <= '0;
            addr2_q   <= '0;
            di_q      <= '0;
            out_q     <= '0;
            ov_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            x_q       <= x_d;
            fbg_q     <= fbg_d;
            mixg_q    <= mixg_d;
            we_q      <= we_d;
            addr1_q   <= addr1_d;
            addr2_q   <= addr2_d;
            di_q      <= di_d;
            out_q     <= out_d;
            ov_q      <= ov_d;
            overrun_q <= overrun_d;
        end
    end

    assign bram_we    = we_q;
    assign bram_addr1 = addr1_q;
    assign bram_addr2 = addr2_q;
    assign bram_di    = di_q;
    assign sample_out = out_q;
    assign out_valid  = ov_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_echo_ctrl.sv
// Directed bench: full-size instance for sweep/datapath, a 24-word instance for wrap,
// coincident clear and reset-during-clear.
module tb_echo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               a_rst_n, s_rst_n, sel;
    logic               d_sv, d_clr;
    logic signed [23:0] d_x;
    logic [14:0]        d_dl;
    logic [7:0]         d_fb, d_mix;

    logic               a_we, s_we, a_ov, s_ov, a_busy, s_busy, a_ovr, s_ovr;
    logic [14:0]        a_addr1, a_addr2, s_addr1, s_addr2;
    logic [31:0]        a_di, s_di, a_do2, s_do2;
    logic signed [23:0] a_out, s_out;

    logic               poke_en;
    logic [14:0]        poke_addr;
    logic [31:0]        poke_data;
    logic [31:0]        a_mem [0:19999];
    logic [31:0]        s_mem [0:23];

    echo_ctrl u_dut_a (
        .clk (clk), .rst_n (a_rst_n), .sample_valid (d_sv & ~sel), .sample_in (d_x),
        .delay_len (d_dl), .fb_gain (d_fb), .mix_gain (d_mix), .clear_req (d_clr & ~sel),
        .bram_we (a_we), .bram_addr1 (a_addr1), .bram_addr2 (a_addr2), .bram_di (a_di),
        .bram_do2 (a_do2), .sample_out (a_out), .out_valid (a_ov), .busy (a_busy),
        .overrun (a_ovr)
    );

    echo_ctrl #(.T(24)) u_dut_s (
        .clk (clk), .rst_n (s_rst_n), .sample_valid (d_sv & sel), .sample_in (d_x),
        .delay_len (d_dl), .fb_gain (d_fb), .mix_gain (d_mix), .clear_req (d_clr & sel),
        .bram_we (s_we), .bram_addr1 (s_addr1), .bram_addr2 (s_addr2), .bram_di (s_di),
        .bram_do2 (s_do2), .sample_out (s_out), .out_valid (s_ov), .busy (s_busy),
        .overrun (s_ovr)
    );

    always @(posedge clk) begin
        if (poke_en) a_mem[poke_addr] <= poke_data;
        else if (a_we) a_mem[a_addr1] <= a_di;
        a_do2 <= a_mem[a_addr2];
    end

    always @(posedge clk) begin
        if (s_we) s_mem[s_addr1] <= s_di;
        s_do2 <= s_mem[s_addr2];
    end

    wire               o_we    = sel ? s_we : a_we;
    wire               o_ov    = sel ? s_ov : a_ov;
    wire               o_busy  = sel ? s_busy : a_busy;
    wire               o_ovr   = sel ? s_ovr : a_ovr;
    wire [14:0]        o_addr1 = sel ? s_addr1 : a_addr1;
    wire [14:0]        o_addr2 = sel ? s_addr2 : a_addr2;
    wire [31:0]        o_di    = sel ? s_di : a_di;
    wire signed [23:0] o_out   = sel ? s_out : a_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [14:0]        obs_addr1, obs_addr2;
    logic [31:0]        obs_di;
    logic signed [23:0] obs_out;
    logic               obs_ov3, obs_busy4, obs_ovr2;
    int                 obs_we_cnt, obs_ovr_cnt, obs_ov_bad;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic note();
        obs_we_cnt  += int'(o_we);
        obs_ovr_cnt += int'(o_ovr);
        if (o_ov) obs_ov_bad++;
    endtask

    // One accept from IDLE; optional stray strobe in RD and clear request in CALC.
    task automatic run_op(input logic signed [23:0] x, input logic [14:0] dl,
                          input logic [7:0] fb, input logic [7:0] mg,
                          input logic inj_sv, input logic inj_clr);
        obs_we_cnt = 0; obs_ovr_cnt = 0; obs_ov_bad = 0;
        d_x = x; d_dl = dl; d_fb = fb; d_mix = mg; d_sv = 1'b1;
        tick();
        obs_addr2 = o_addr2; note(); d_sv = inj_sv;
        tick();
        obs_ovr2 = o_ovr; note(); d_sv = 1'b0; d_clr = inj_clr;
        tick();
        d_clr = 1'b0;
        obs_addr1 = o_addr1; obs_di = o_di; obs_out = o_out; obs_ov3 = o_ov;
        obs_we_cnt += int'(o_we); obs_ovr_cnt += int'(o_ovr);
        tick();
        obs_busy4 = o_busy; note();
    endtask

    task automatic poke(input logic [14:0] addr, input logic [31:0] data);
        poke_addr = addr; poke_data = data; poke_en = 1'b1;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks++; if (a_busy !== 1'b1) begin n_errors++; $display("FAIL reset_busy: got %b want 1", a_busy); end
        n_checks++; if (a_we !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %b want 0", a_we); end
        n_checks++; if (a_addr1 !== 15'd0 || a_addr2 !== 15'd0) begin n_errors++; $display("FAIL reset_addr: got %0d/%0d want 0/0", a_addr1, a_addr2); end
        n_checks++; if (a_di !== 32'd0) begin n_errors++; $display("FAIL reset_di: got %h want 0", a_di); end
        n_checks++; if (a_out !== 24'sd0) begin n_errors++; $display("FAIL reset_out: got %0d want 0", a_out); end
        n_checks++; if (a_ov !== 1'b0 || a_ovr !== 1'b0) begin n_errors++; $display("FAIL reset_strobes: got %b%b want 00", a_ov, a_ovr); end
        n_checks++; if (s_busy !== 1'b1) begin n_errors++; $display("FAIL reset_busy_small: got %b want 1", s_busy); end
    endtask

    task automatic test_clear_sweep();
        int bad = 0;
        a_rst_n = 1'b1; s_rst_n = 1'b1;
        for (int k = 0; k < 20000; k++) begin
            tick();
            if (a_we !== 1'b1 || a_busy !== 1'b1 || a_addr1 !== 15'(k) || a_di !== 32'd0) bad++;
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL clear_sweep: got %0d bad cycles want 0", bad); end
        tick();
        n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL clear_end_busy: got %b want 0", a_busy); end
        n_checks++; if (a_we !== 1'b0) begin n_errors++; $display("FAIL clear_end_we: got %b want 0", a_we); end
    endtask

    task automatic test_impulse();
        int exp_out [6] = '{1000, 0, 0, 0, 500, 0};
        for (int i = 0; i < 6; i++) begin
            run_op((i == 0) ? 24'sd1000 : 24'sd0, 15'd4, 8'd0, 8'd128, 1'b0, 1'b0);
            n_checks++; if (obs_out !== 24'(exp_out[i]) || obs_ov3 !== 1'b1 || obs_ov_bad != 0) begin
                n_errors++; $display("FAIL impulse[%0d]: got %0d valid %b stray %0d want %0d valid 1 stray 0", i, obs_out, obs_ov3, obs_ov_bad, exp_out[i]);
            end
            if (i == 0) begin
                n_checks++; if (obs_addr2 !== 15'd19996 || obs_di !== 32'd1000) begin n_errors++; $display("FAIL impulse_first: got addr2 %0d di %0d want 19996 1000", obs_addr2, obs_di); end
                n_checks++; if (obs_ovr_cnt != 0 || obs_we_cnt != 1) begin n_errors++; $display("FAIL impulse_ctl: got overrun %0d writes %0d want 0 1", obs_ovr_cnt, obs_we_cnt); end
            end
        end
    endtask

    task automatic test_floor_and_saturation();
        poke(15'd5, 32'hFFFF_FFFD);
        run_op(24'sd0, 15'd1, 8'd128, 8'd128, 1'b0, 1'b0);
        n_checks++; if (obs_out !== -24'sd2 || obs_di !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL floor: got %0d di %h want -2 fffffffe", obs_out, obs_di); end
        poke(15'd6, 32'h007F_FFFF);
        run_op(24'sd8388000, 15'd1, 8'd255, 8'd255, 1'b0, 1'b0);
        n_checks++; if (obs_out !== 24'sd8388607 || obs_di !== 32'h007F_FFFF) begin n_errors++; $display("FAIL sat_pos: got %0d di %h want 8388607 007fffff", obs_out, obs_di); end
        poke(15'd7, 32'hFF80_0000);
        run_op(-24'sd8388000, 15'd1, 8'd255, 8'd255, 1'b0, 1'b0);
        n_checks++; if (obs_out !== 24'sh80_0000 || obs_di !== 32'hFF80_0000) begin n_errors++; $display("FAIL sat_neg: got %0d di %h want -8388608 ff800000", obs_out, obs_di); end
    endtask

    task automatic test_delay_clamp();
        run_op(24'sd0, 15'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        n_checks++; if (obs_addr2 !== 15'd8) begin n_errors++; $display("FAIL delay_zero: got %0d want 8", obs_addr2); end
        run_op(24'sd0, 15'd25000, 8'd0, 8'd0, 1'b0, 1'b0);
        n_checks++; if (obs_addr2 !== 15'd11) begin n_errors++; $display("FAIL delay_big: got %0d want 11", obs_addr2); end
    endtask

    task automatic test_back_to_back();
        run_op(24'sd0, 15'd3, 8'd0, 8'd0, 1'b1, 1'b0);
        n_checks++; if (obs_ovr2 !== 1'b1 || obs_ovr_cnt != 1) begin n_errors++; $display("FAIL overrun_pulse: got %b count %0d want 1 1", obs_ovr2, obs_ovr_cnt); end
        n_checks++; if (obs_we_cnt != 1 || obs_addr1 !== 15'd11) begin n_errors++; $display("FAIL overrun_write: got %0d writes addr %0d want 1 11", obs_we_cnt, obs_addr1); end
        run_op(24'sd0, 15'd1, 8'd0, 8'd0, 1'b0, 1'b1);
        n_checks++; if (obs_addr2 !== 15'd11 || obs_addr1 !== 15'd12) begin n_errors++; $display("FAIL overrun_ptr: got rd %0d wr %0d want 11 12", obs_addr2, obs_addr1); end
        tick();
        n_checks++; if (obs_busy4 !== 1'b0 || a_busy !== 1'b0 || obs_ovr_cnt != 0) begin n_errors++; $display("FAIL busy_clear_ignored: got busy %b/%b overrun %0d want 0/0 0", obs_busy4, a_busy, obs_ovr_cnt); end
    endtask

    task automatic test_wrap();
        sel = 1'b1;
        for (int i = 0; i < 22; i++) run_op(24'sd0, 15'd1, 8'd0, 8'd0, 1'b0, 1'b0);
        run_op(24'sd0, 15'd5, 8'd0, 8'd0, 1'b0, 1'b0);
        n_checks++; if (obs_addr2 !== 15'd17 || obs_addr1 !== 15'd22) begin n_errors++; $display("FAIL wrap_rd_high: got rd %0d wr %0d want 17 22", obs_addr2, obs_addr1); end
        run_op(24'sd0, 15'd1, 8'd0, 8'd0, 1'b0, 1'b0);
        run_op(24'sd0, 15'd1, 8'd0, 8'd0, 1'b0, 1'b0);
        n_checks++; if (obs_addr1 !== 15'd0 || obs_addr2 !== 15'd23) begin n_errors++; $display("FAIL wrap_ptr: got wr %0d rd %0d want 0 23", obs_addr1, obs_addr2); end
        run_op(24'sd0, 15'd1, 8'd0, 8'd0, 1'b0, 1'b0);
        run_op(24'sd0, 15'd5, 8'd0, 8'd0, 1'b0, 1'b0);
        n_checks++; if (obs_addr2 !== 15'd21) begin n_errors++; $display("FAIL wrap_rd_low: got %0d want 21", obs_addr2); end
        run_op(24'sd0, 15'd30, 8'd0, 8'd0, 1'b0, 1'b0);
        n_checks++; if (obs_addr2 !== 15'd4) begin n_errors++; $display("FAIL wrap_clamp: got %0d want 4", obs_addr2); end
    endtask

    task automatic sweep_small(input string tag);
        int writes = 0;
        int bad = 0;
        for (int c = 0; c < 100 && s_busy; c++) begin
            tick();
            if (s_we) begin
                if (s_addr1 !== 15'(writes) || s_di !== 32'd0) bad++;
                writes++;
            end
        end
        n_checks++; if (writes != 24 || bad != 0 || s_busy !== 1'b0) begin
            n_errors++; $display("FAIL %s: got %0d writes %0d bad busy %b want 24 0 0", tag, writes, bad, s_busy);
        end
    endtask

    task automatic test_clear_coincident();
        d_sv = 1'b1; d_clr = 1'b1;
        tick();
        d_sv = 1'b0; d_clr = 1'b0;
        n_checks++; if (s_ovr !== 1'b1 || s_busy !== 1'b1) begin n_errors++; $display("FAIL coincident: got overrun %b busy %b want 1 1", s_ovr, s_busy); end
        sweep_small("coincident_sweep");
        run_op(24'sd0, 15'd1, 8'd0, 8'd0, 1'b0, 1'b0);
        n_checks++; if (obs_addr1 !== 15'd0 || obs_addr2 !== 15'd23) begin n_errors++; $display("FAIL post_clear_ptr: got wr %0d rd %0d want 0 23", obs_addr1, obs_addr2); end
    endtask

    task automatic test_reset_mid_clear();
        d_clr = 1'b1;
        tick();
        d_clr = 1'b0;
        repeat (6) tick();
        s_rst_n = 1'b0;
        repeat (2) tick();
        n_checks++; if (s_busy !== 1'b1 || s_we !== 1'b0 || s_addr1 !== 15'd0) begin n_errors++; $display("FAIL reset_mid_clear: got busy %b we %b addr %0d want 1 0 0", s_busy, s_we, s_addr1); end
        s_rst_n = 1'b1;
        sweep_small("restart_sweep");
    endtask

    initial begin
        a_rst_n = 1'b0; s_rst_n = 1'b0; sel = 1'b0; poke_en = 1'b0;
        poke_addr = '0; poke_data = '0;
        d_sv = 1'b0; d_clr = 1'b0; d_x = '0; d_dl = '0; d_fb = '0; d_mix = '0;
        test_reset();
        test_clear_sweep();
        test_impulse();
        test_floor_and_saturation();
        test_delay_clamp();
        test_back_to_back();
        test_wrap();
        test_clear_coincident();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/echo_ctrl.md
ECHO_CTRL -- requirements
Module: echo_ctrl

Interface
REQ-001 SHALL have parameter T, default 20000, delay-line depth in words.
REQ-002 SHALL have parameter B, default 15, address width.
REQ-003 SHALL have parameter DW, default 24, signed audio sample width.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 sample_valid  in  1  single-cycle strobe, new input sample.
REQ-007 sample_in  in  DW  signed dry sample.
REQ-008 delay_len  in  B  delay in samples, captured on accept.
REQ-009 fb_gain  in  8  unsigned feedback gain, value/256, captured on accept.
REQ-010 mix_gain  in  8  unsigned wet-mix gain, value/256, captured on accept.
REQ-011 clear_req  in  1  pulse; zero the whole delay line.
REQ-012 bram_we  out  1  write enable to the 32-bit dual-read RAM.
REQ-013 bram_addr1  out  B  write/read-port-1 address.
REQ-014 bram_addr2  out  B  read-port-2 address.
REQ-015 bram_di  out  32  write data, sample sign-extended to 32 bits.
REQ-016 bram_do2  in  32  port-2 read data, one-cycle registered latency.
REQ-017 sample_out  out  DW  signed processed sample.
REQ-018 out_valid  out  1  single-cycle strobe qualifying sample_out.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 overrun  out  1  single-cycle pulse, sample_valid dropped.

Function
REQ-021 States SHALL be CLEAR, IDLE, RD, CALC, WR.
REQ-022 IDLE + sample_valid (cycle n) -> capture sample, gains, effective delay; RD in n+1, CALC n+2, WR n+3, IDLE n+4.
REQ-023 Effective delay d SHALL be 1 if delay_len=0, T-1 if delay_len>=T, else delay_len.
REQ-024 Read address SHALL be (wr_ptr - d) mod T, driven on bram_addr2 during RD.
REQ-025 In CALC, wet = bram_do2[DW-1:0] signed; wet term products SHALL be floor (arithmetic shift) of wet*gain/256.
REQ-026 fb_val = sat(x + wet*fb_gain/256); out_val = sat(x + wet*mix_gain/256); sat clamps to [-2^(DW-1), 2^(DW-1)-1].
REQ-027 In WR: bram_we=1, bram_addr1=wr_ptr, bram_di=sign-extended fb_val; out_valid=1, sample_out=out_val; wr_ptr SHALL then advance, wrapping T-1 -> 0.
REQ-028 bram_we SHALL be 0 outside WR and CLEAR.
REQ-029 sample_valid while busy SHALL be ignored and pulse overrun the next cycle; state and wr_ptr unaffected.
REQ-030 clear_req in IDLE -> CLEAR; if coincident with sample_valid, clear_req wins and overrun pulses.
REQ-031 clear_req while busy SHALL be ignored.
REQ-032 CLEAR SHALL write 0 to addresses 0..T-1, one per cycle, exactly T cycles, then IDLE with wr_ptr=0.
REQ-033 sample_out SHALL hold its value between out_valid strobes.

Reset
REQ-034 rst_n low at a clock edge SHALL force state CLEAR with clear counter 0, wr_ptr 0, bram_we 0, both addresses 0, bram_di 0, sample_out 0, out_valid 0, overrun 0, busy 1.
REQ-035 Reset asserted mid-CLEAR or mid-sample SHALL abandon the operation; sweep restarts from address 0 after release.

Structure
REQ-036 Package echo_pkg SHALL hold T, B, DW defaults, the state enum and the saturate function.
REQ-037 Sub-module echo_mac SHALL compute sat(x + wet*gain/256); instantiated twice (feedback, mix).

Verification
REQ-038 Reset release -> busy high exactly 20000 cycles, bram_we high each, bram_addr1 0..19999 ascending, then busy 0.
REQ-039 delay_len=4, fb_gain=0, mix_gain=128, impulse 1000 then zeros -> outputs 1000,0,0,0,500,0; out_valid 3 cycles after each accept.
REQ-040 wr_ptr=19998, delay 5 -> bram_addr2=19993; wr_ptr=2, delay 5 -> bram_addr2=19997; wr_ptr wraps 19999 -> 0.
REQ-041 x=8388000, stored wet=8388607, fb_gain=255, mix_gain=255 -> bram_di=0x007FFFFF, sample_out=8388607; x=-8388000, wet=-8388608 -> -8388608.
REQ-042 sample_valid during RD -> overrun pulse, one write only, wr_ptr advanced by 1.
REQ-043 delay_len=0 -> bram_addr2=wr_ptr-1; delay_len=25000 -> delay 19999.
